// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done pulses WIDTH cycles after start.
// No backpressure: start is taken only in IDLE/DONE and silently dropped while busy.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    step_cnt;
  logic             dbz_pend;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (step_cnt == LAST_STEP);

  // Partial remainder is held in WIDTH bits: after any restore it is below the
  // divisor, and the shifted value's top bit only feeds the trial subtract.
  always_comb begin
    p_shift  = {prem, dvd_sh[WIDTH-1]};
    trial    = p_shift - {1'b0, dvs_r};
    q_bit    = ~trial[WIDTH];
    prem_nxt = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
    dvd_nxt  = {dvd_sh[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (step_cnt == LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Dividend register doubles as the quotient shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_sh      <= '0;
      dvs_r       <= '0;
      prem        <= '0;
      step_cnt    <= '0;
      dbz_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sh   <= dividend;
      dvs_r    <= divisor;
      prem     <= '0;
      step_cnt <= '0;
      dbz_pend <= (divisor == '0);
    end else if (state == RUN) begin
      dvd_sh   <= dvd_nxt;
      prem     <= prem_nxt;
      step_cnt <= step_cnt + 1'b1;
      if (last_step) begin
        quotient    <= dvd_nxt;
        remainder   <= prem_nxt;
        div_by_zero <= dbz_pend;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider at WIDTH=4.
// Expected results queued at issue, popped and compared at each done.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int issue_cyc = 0;
  int done_cnt  = 0;
  int snap      = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (track) begin
      e.q   = (b == '0) ? {W{1'b1}} : a / b;
      e.r   = (b == '0) ? a : a % b;
      e.dbz = (b == '0);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    if (track) issue_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - issue_cyc), 32'd4);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(quotient), 32'(e.q));
      chk({tag, "_r"}, 32'(remainder), 32'(e.r));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    tick();

    // T1: 13/4, then results held in IDLE and done drops after one cycle
    issue(4'd13, 4'd4, 1'b1);
    wait_done("t1");
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_hold_q", 32'(quotient), 32'd3);
    chk("t1_hold_r", 32'(remainder), 32'd1);
    tick();

    // T2
    issue(4'd15, 4'd1, 1'b1);
    wait_done("t2a");
    tick();
    issue(4'd5, 4'd7, 1'b1);
    wait_done("t2b");
    tick();
    issue(4'd0, 4'd3, 1'b1);
    wait_done("t2c");
    tick();

    // T3: divide by zero, flag held, then cleared by a normal divide
    issue(4'd9, 4'd0, 1'b1);
    wait_done("t3a");
    tick();
    chk("t3_dbz_hold", 32'(div_by_zero), 32'd1);
    issue(4'd8, 4'd2, 1'b1);
    wait_done("t3b");
    tick();

    // T4: start while busy is ignored
    snap = done_cnt;
    issue(4'd13, 4'd4, 1'b1);
    tick();
    dividend = 4'd6;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4");
    repeat (8) tick();
    chk("t4_single_done", 32'(done_cnt - snap), 32'd1);
    chk("t4_hold_q", 32'(quotient), 32'd3);

    // T5: back-to-back start during the done cycle
    issue(4'd14, 4'd3, 1'b1);
    wait_done("t5a");
    issue(4'd12, 4'd5, 1'b1);
    wait_done("t5b");
    tick();

    // T6: reset mid-operation aborts with no done
    tick();
    snap = done_cnt;
    issue(4'd11, 4'd2, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_q", 32'(quotient), 32'd0);
    chk("t6_r", 32'(remainder), 32'd0);
    repeat (8) tick();
    chk("t6_no_done", 32'(done_cnt - snap), 32'd0);
    issue(4'd11, 4'd2, 1'b1);
    wait_done("t6b");
    tick();

    // Reset and start on the same edge: start dropped
    snap     = done_cnt;
    dividend = 4'd7;
    divisor  = 4'd1;
    start    = 1'b1;
    reset    = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_q", 32'(quotient), 32'd0);
    repeat (6) tick();
    chk("rs_no_done", 32'(done_cnt - snap), 32'd0);
    chk("rs_idle_busy", 32'(busy), 32'd0);

    // Exhaustive sweep, issued back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a[W-1:0], b[W-1:0], 1'b1);
        wait_done("sweep");
        if (b != 0) begin
          chk("sweep_inv_sum", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
          chk("sweep_inv_lt", 32'(int'(remainder) < b), 32'd1);
        end
      end
    end
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
